ula_ctrl: RTL and testbench

//  Command-side driver for the 4-bit ULA: buffers a stream of op commands, drives op_a/op_b/sel_ULA,

---
 rtl/ula_pkg.sv | 53 +++++
 rtl/ula.sv | 14 +
 rtl/ula_cmd_fifo.sv | 50 +++++
 rtl/ula_ctrl.sv | 134 +++++++++++++
 tb/tb_ula_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared types for the 4-bit ULA and its command-side controller:
// select codes, FSM states, the command word layout and the ULA function.
package ula_pkg;

   localparam int ULA_W     = 4;
   localparam int ULA_SEL_W = 3;

   typedef enum logic [ULA_SEL_W-1:0] {
      SEL_PASS_A = 3'b000,
      SEL_NOT_A  = 3'b001,
      SEL_PASS_B = 3'b010,
      SEL_NOT_B  = 3'b011,
      SEL_AND    = 3'b100,
      SEL_NAND_A = 3'b101,
      SEL_AND_NB = 3'b110,
      SEL_NOR    = 3'b111
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_RESULT = 2'd2
   } state_e;

   typedef struct packed {
      logic                 load;
      logic [ULA_SEL_W-1:0] sel;
      logic [ULA_W-1:0]     b;
      logic                 last;
   } cmd_t;

   function automatic logic [ULA_W-1:0] ula_eval(
      input logic [ULA_W-1:0]     a,
      input logic [ULA_W-1:0]     b,
      input logic [ULA_SEL_W-1:0] sel
   );
      logic [ULA_W-1:0] y;
      y = '0;
      unique case (sel)
         SEL_PASS_A: y = a;
         SEL_NOT_A:  y = ~a;
         SEL_PASS_B: y = b;
         SEL_NOT_B:  y = ~b;
         SEL_AND:    y = a & b;
         SEL_NAND_A: y = ~a & b;
         SEL_AND_NB: y = a & ~b;
         SEL_NOR:    y = ~(a | b);
         default:    y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/ula.sv
// Combinational 4-bit ULA: eight bitwise functions selected by sel_i.
// Pure logic, no state.
module ula
   import ula_pkg::*;
(
   input  logic [ULA_W-1:0]     a_i,
   input  logic [ULA_W-1:0]     b_i,
   input  logic [ULA_SEL_W-1:0] sel_i,
   output logic [ULA_W-1:0]     y_o
);

   assign y_o = ula_eval(a_i, b_i, sel_i);

endmodule

// File: rtl/ula_cmd_fifo.sv
// Synchronous command FIFO, registered storage, no write-to-read bypass.
// Pushes when full and pops when empty are ignored.
module ula_cmd_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ula_ctrl.sv
// Command-side driver for the 4-bit ULA: command FIFO, accumulator, result port.
// Define ULA_CTRL_ZFLAG_EN to add the res_zero output.
module ula_ctrl
   import ula_pkg::*;
#(
   parameter int W     = ULA_W,
   parameter int SEL_W = ULA_SEL_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [SEL_W-1:0] cmd_sel,
   input  logic [W-1:0]     cmd_b,
   input  logic             cmd_last,
   output logic [W-1:0]     op_a,
   output logic [W-1:0]     op_b,
   output logic [SEL_W-1:0] sel_ULA,
   input  logic [W-1:0]     ula_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data
`ifdef ULA_CTRL_ZFLAG_EN
   ,
   output logic             res_zero
`endif
);

   localparam int CMD_W = $bits(cmd_t);

   cmd_t             push_cmd, head;
   logic [CMD_W-1:0] fifo_dout;
   logic             full, empty, pop;

   state_e           state_q;
   logic [W-1:0]     acc_q, op_a_q, op_b_q, res_data_q;
   logic [SEL_W-1:0] sel_q;
   logic             res_valid_q, last_q;
`ifdef ULA_CTRL_ZFLAG_EN
   logic             zero_q;
`endif

   assign push_cmd  = '{load: cmd_load, sel: cmd_sel, b: cmd_b, last: cmd_last};
   assign head      = cmd_t'(fifo_dout);
   assign cmd_ready = !full;
   assign pop       = (state_q == ST_IDLE) && !empty;

   ula_cmd_fifo #(
      .DW    (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_valid),
      .data_i  (push_cmd),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sel_q       <= '0;
         last_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
`ifdef ULA_CTRL_ZFLAG_EN
         zero_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  if (head.load) begin
                     acc_q <= head.b;
                     if (head.last) begin
                        res_data_q  <= head.b;
                        res_valid_q <= 1'b1;
`ifdef ULA_CTRL_ZFLAG_EN
                        zero_q      <= (head.b == '0);
`endif
                        state_q     <= ST_RESULT;
                     end
                  end else begin
                     op_a_q  <= acc_q;
                     op_b_q  <= head.b;
                     sel_q   <= head.sel;
                     last_q  <= head.last;
                     state_q <= ST_EXEC;
                  end
               end
            end
            // ULA output settles from the registered operands in one cycle.
            ST_EXEC: begin
               acc_q <= ula_out;
               if (last_q) begin
                  res_data_q  <= ula_out;
                  res_valid_q <= 1'b1;
`ifdef ULA_CTRL_ZFLAG_EN
                  zero_q      <= (ula_out == '0);
`endif
                  state_q     <= ST_RESULT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign sel_ULA   = sel_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
`ifdef ULA_CTRL_ZFLAG_EN
   assign res_zero  = zero_q;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl driving a real ULA: directed table, corner sequences,
// and random command streams against a program-level accumulator model.
module tb_ula_ctrl;

   localparam logic [2:0] S_PASS_A = 3'd0;
   localparam logic [2:0] S_NOT_A  = 3'd1;
   localparam logic [2:0] S_PASS_B = 3'd2;
   localparam logic [2:0] S_NOT_B  = 3'd3;
   localparam logic [2:0] S_AND    = 3'd4;
   localparam logic [2:0] S_NAND_A = 3'd5;
   localparam logic [2:0] S_AND_NB = 3'd6;
   localparam logic [2:0] S_NOR    = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_load = 1'b0;
   logic [2:0] cmd_sel = '0;
   logic [3:0] cmd_b = '0;
   logic       cmd_last = 1'b0;
   logic [3:0] op_a, op_b, ula_out, res_data;
   logic [2:0] sel_ULA;
   logic       res_valid;
   logic       res_ready = 1'b0;
`ifdef ULA_CTRL_ZFLAG_EN
   logic       res_zero;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ula u_ula (
      .a_i   (op_a),
      .b_i   (op_b),
      .sel_i (sel_ULA),
      .y_o   (ula_out)
   );

   ula_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_load  (cmd_load),
      .cmd_sel   (cmd_sel),
      .cmd_b     (cmd_b),
      .cmd_last  (cmd_last),
      .op_a      (op_a),
      .op_b      (op_b),
      .sel_ULA   (sel_ULA),
      .ula_out   (ula_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
`ifdef ULA_CTRL_ZFLAG_EN
      ,
      .res_zero  (res_zero)
`endif
   );

   function automatic logic [3:0] ref_ula(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] s);
      case (s)
         S_PASS_A: return a;
         S_NOT_A:  return ~a;
         S_PASS_B: return b;
         S_NOT_B:  return ~b;
         S_AND:    return a & b;
         S_NAND_A: return ~a & b;
         S_AND_NB: return a & ~b;
         default:  return ~(a | b);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns whether the command was accepted.
   task automatic push(input logic ld, input logic [2:0] s, input logic [3:0] b,
                       input logic lst, output logic acc);
      cmd_valid = 1'b1;
      cmd_load  = ld;
      cmd_sel   = s;
      cmd_b     = b;
      cmd_last  = lst;
      acc       = cmd_ready;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_res();
      int n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("res_timeout", 32'(res_valid), 32'd1);
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [2:0] s;
      logic [3:0] b;
      logic [3:0] exp;
   } vec_t;

   vec_t       vt[10];
   logic       acc_f;
   logic [3:0] oa, ob, macc, pd;
   logic [2:0] os;
   logic       pv, pr;
   logic [3:0] expq[$];

   initial begin
      vt[0] = '{4'hA, S_PASS_A, 4'h6, 4'hA};
      vt[1] = '{4'hA, S_NOT_A,  4'h6, 4'h5};
      vt[2] = '{4'hA, S_PASS_B, 4'h6, 4'h6};
      vt[3] = '{4'hA, S_NOT_B,  4'h6, 4'h9};
      vt[4] = '{4'hA, S_AND,    4'h6, 4'h2};
      vt[5] = '{4'hA, S_NAND_A, 4'h6, 4'h4};
      vt[6] = '{4'hA, S_AND_NB, 4'h6, 4'h8};
      vt[7] = '{4'hA, S_NOR,    4'h6, 4'h1};
      vt[8] = '{4'h3, S_AND_NB, 4'h3, 4'h0};
      vt[9] = '{4'h0, S_NOR,    4'h0, 4'hF};

      do_reset();
      chk("rst_op_a", 32'(op_a), 32'd0);
      chk("rst_op_b", 32'(op_b), 32'd0);
      chk("rst_sel", 32'(sel_ULA), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ULA_CTRL_ZFLAG_EN
      chk("rst_res_zero", 32'(res_zero), 32'd0);
`endif

      // Spec program: load A, NOT_A, AND 6 -> 4, AND issued with op_a=5.
      push(1'b1, S_PASS_A, 4'hA, 1'b0, acc_f);
      push(1'b0, S_NOT_A, 4'h0, 1'b0, acc_f);
      push(1'b0, S_AND, 4'h6, 1'b1, acc_f);
      wait_res();
      chk("prog1_data", 32'(res_data), 32'h4);
      chk("prog1_op_a", 32'(op_a), 32'h5);
      chk("prog1_op_b", 32'(op_b), 32'h6);
      chk("prog1_sel", 32'(sel_ULA), 32'(S_AND));
      take_res();

      for (int i = 0; i < 10; i++) begin
         push(1'b1, S_PASS_A, vt[i].a, 1'b0, acc_f);
         push(1'b0, vt[i].s, vt[i].b, 1'b1, acc_f);
         wait_res();
         chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(vt[i].exp));
         chk($sformatf("vec%0d_op_a", i), 32'(op_a), 32'(vt[i].a));
         chk($sformatf("vec%0d_op_b", i), 32'(op_b), 32'(vt[i].b));
         chk($sformatf("vec%0d_sel", i), 32'(sel_ULA), 32'(vt[i].s));
`ifdef ULA_CTRL_ZFLAG_EN
         chk($sformatf("vec%0d_zero", i), 32'(res_zero), 32'(vt[i].exp == 4'h0));
`endif
         take_res();
      end

      // Accumulator persists into the next program.
      push(1'b0, S_PASS_A, 4'h5, 1'b1, acc_f);
      wait_res();
      chk("acc_persist", 32'(res_data), 32'hF);
      take_res();

      // Back-pressure on the result: FIFO fills, nothing is popped.
      push(1'b1, S_PASS_A, 4'h1, 1'b1, acc_f);
      wait_res();
      chk("load_last_data", 32'(res_data), 32'h1);
      oa = op_a; ob = op_b; os = sel_ULA;
      push(1'b0, S_NOT_A, 4'h0, 1'b0, acc_f);
      chk("full_acc0", 32'(acc_f), 32'd1);
      push(1'b0, S_PASS_B, 4'h3, 1'b0, acc_f);
      chk("full_acc1", 32'(acc_f), 32'd1);
      push(1'b0, S_AND, 4'h7, 1'b0, acc_f);
      chk("full_acc2", 32'(acc_f), 32'd1);
      push(1'b0, S_NOR, 4'h8, 1'b1, acc_f);
      chk("full_acc3", 32'(acc_f), 32'd1);
      push(1'b1, S_PASS_A, 4'hF, 1'b1, acc_f);
      chk("full_reject", 32'(acc_f), 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_data", 32'(res_data), 32'h1);
         chk("hold_ops", 32'({op_a, op_b, sel_ULA}), 32'({oa, ob, os}));
         chk("hold_full", 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      begin
         int n = 0;
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("op_latency", 32'(n), 32'd8);
         chk("queued_data", 32'(res_data), 32'h4);
      end
      take_res();
      for (int k = 0; k < 6; k++) begin
         chk("no_rejected_exec", 32'(res_valid), 32'd0);
         @(negedge clk);
      end

      // Reset while a ULA op is in flight.
      push(1'b1, S_PASS_A, 4'h5, 1'b0, acc_f);
      push(1'b0, S_NOT_A, 4'h0, 1'b0, acc_f);
      push(1'b0, S_PASS_B, 4'h9, 1'b1, acc_f);
      chk("exec_op_a", 32'(op_a), 32'h5);
      chk("exec_sel", 32'(sel_ULA), 32'(S_NOT_A));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ops", 32'({op_a, op_b, sel_ULA}), 32'd0);
      chk("mid_rst_res", 32'({res_valid, res_data}), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin
         chk("mid_rst_flushed", 32'(res_valid), 32'd0);
         @(negedge clk);
      end
      push(1'b0, S_PASS_A, 4'h7, 1'b1, acc_f);
      wait_res();
      chk("mid_rst_acc", 32'(res_data), 32'h0);
      take_res();

      // Random streams against the program-level model.
      do_reset();
      macc = '0;
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (int c = 0; c < 800; c++) begin
         if (pv && !pr)
            chk("rand_hold", 32'({res_valid, res_data}), 32'({1'b1, pd}));
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_load  = ($urandom_range(0, 3) == 0);
         cmd_sel   = 3'($urandom);
         cmd_b     = 4'($urandom);
         cmd_last  = ($urandom_range(0, 4) == 0);
         res_ready = ($urandom_range(0, 2) == 0);
         if (res_valid && res_ready) begin
            if (expq.size() == 0) chk("rand_extra", 32'(expq.size()), 32'd1);
            else chk("rand_data", 32'(res_data), 32'(expq.pop_front()));
         end
         if (cmd_valid && cmd_ready) begin
            macc = cmd_load ? cmd_b : ref_ula(macc, cmd_b, cmd_sel);
            if (cmd_last) expq.push_back(macc);
         end
         pv = res_valid; pr = res_ready; pd = res_data;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 200 && expq.size() > 0; c++) begin
         if (res_valid) chk("drain_data", 32'(res_data), 32'(expq.pop_front()));
         @(negedge clk);
      end
      res_ready = 1'b0;
      chk("drain_left", 32'(expq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
